// File: rtl/stream_calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_calc_pkg
// Description : Shared opcode / error-code encodings and default sizing for
//               the streaming calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_calc_pkg;

    localparam int c_default_width = 8;
    localparam int c_default_depth = 8;

    // Fractional bits used by the fixed-point divide (Q4.4 for 8-bit data)
    localparam int c_frac_bits = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_FDIV = 3'd4,
        OP_PUSH = 3'd5,
        OP_POP  = 3'd6,
        OP_INV  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_BAD_OP    = 3'd1,
        ERR_UNDERFLOW = 3'd2,
        ERR_OVERFLOW  = 3'd3,
        ERR_DIV_ZERO  = 3'd4
    } err_e;

    // Opcodes 0..4 consume two operands and produce one
    function automatic logic is_binary(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_FDIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_calc_alu.sv
`default_nettype none
// ============================================================================
// Module      : stream_calc_alu
// Description : Combinational arithmetic core. Computes R = Y op X and flags
//               a zero divisor for the two divide opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_calc_alu
    import stream_calc_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_r,
    output logic             o_div_zero
);

    localparam int c_fdiv_w = WIDTH + c_frac_bits;

    logic [WIDTH-1:0]    w_safe_x;
    logic [WIDTH-1:0]    w_quot;
    logic [c_fdiv_w-1:0] w_fdiv_num;
    logic [c_fdiv_w-1:0] w_fdiv_den;
    logic [c_fdiv_w-1:0] w_fdiv_quot;

    // Divisor forced to 1 when zero so the divider never sees X/0; the
    // result is discarded in that case because the divide-by-zero error wins.
    always_comb begin
        o_div_zero  = (i_x == '0);
        w_safe_x    = o_div_zero ? WIDTH'(1) : i_x;
        w_quot      = i_y / w_safe_x;
        w_fdiv_num  = {i_y, {c_frac_bits{1'b0}}};
        w_fdiv_den  = {{c_frac_bits{1'b0}}, w_safe_x};
        w_fdiv_quot = w_fdiv_num / w_fdiv_den;
    end

    // Opcode select; arithmetic wraps modulo 2^WIDTH
    always_comb begin
        o_r = '0;
        case (i_op)
            OP_ADD:  o_r = i_y + i_x;
            OP_SUB:  o_r = i_y - i_x;
            OP_MUL:  o_r = i_y * i_x;
            OP_DIV:  o_r = w_quot;
            OP_FDIV: o_r = w_fdiv_quot[WIDTH-1:0];
            default: o_r = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stream_calc.sv
`default_nettype none
// ============================================================================
// Module      : stream_calc
// Description : Streaming calculator around a circular operand FIFO. Each
//               applied cycle pushes, pops, or folds the two oldest entries
//               into one result appended at the tail. Errors are sticky and
//               freeze all state until reset. DEPTH must be a power of two
//               and at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_calc
    import stream_calc_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     apply,
    input  logic [WIDTH-1:0]         in,
    input  logic [2:0]               op,
    output logic [WIDTH-1:0]         result,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     err,
    output logic [2:0]               err_code
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_two = c_ptr_w'(2);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_two = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic               r_err;
    err_e               r_err_code;

    op_e                w_op;
    logic               w_binary;
    logic [WIDTH-1:0]   w_x;
    logic [WIDTH-1:0]   w_y;
    logic [WIDTH-1:0]   w_alu_r;
    logic               w_div_zero;
    err_e               w_err_code;
    logic               w_accept;
    logic               w_exec;
    logic               w_fault;

    assign w_op     = op_e'(op);
    assign w_binary = is_binary(w_op);

    // X is the oldest entry, Y the one behind it
    assign w_x = r_mem[r_head];
    assign w_y = r_mem[r_head + c_ptr_one];

    stream_calc_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_x        (w_x),
        .i_y        (w_y),
        .i_op       (w_op),
        .o_r        (w_alu_r),
        .o_div_zero (w_div_zero)
    );

    // Error classification in fixed priority order for the current opcode
    always_comb begin
        w_err_code = ERR_NONE;
        if (w_op == OP_INV) begin
            w_err_code = ERR_BAD_OP;
        end else if (((w_op == OP_POP) && (r_count == '0)) ||
                     (w_binary && (r_count < c_cnt_two))) begin
            w_err_code = ERR_UNDERFLOW;
        end else if ((w_op == OP_PUSH) && (r_count == c_cnt_max)) begin
            w_err_code = ERR_OVERFLOW;
        end else if (((w_op == OP_DIV) || (w_op == OP_FDIV)) && w_div_zero) begin
            w_err_code = ERR_DIV_ZERO;
        end
    end

    // Once an error has latched, apply is ignored entirely
    assign w_accept = apply && !r_err;
    assign w_exec   = w_accept && (w_err_code == ERR_NONE);
    assign w_fault  = w_accept && (w_err_code != ERR_NONE);

    // FIFO storage write: pushed operand or freshly computed result at the tail.
    // When full, a binary op writes the slot at head, which is being consumed
    // this same cycle, so no live entry is overwritten.
    always_ff @(posedge clk) begin
        if (w_exec && (w_op != OP_POP)) begin
            r_mem[r_tail] <= (w_op == OP_PUSH) ? in : w_alu_r;
        end
    end

    // Pointers, occupancy, result register and sticky error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_valid <= 1'b0;
            if (w_exec) begin
                case (w_op)
                    OP_PUSH: begin
                        r_tail  <= r_tail + c_ptr_one;
                        r_count <= r_count + c_cnt_one;
                    end
                    OP_POP: begin
                        r_result <= w_x;
                        r_valid  <= 1'b1;
                        r_head   <= r_head + c_ptr_one;
                        r_count  <= r_count - c_cnt_one;
                    end
                    default: begin
                        r_result <= w_alu_r;
                        r_valid  <= 1'b1;
                        r_head   <= r_head + c_ptr_two;
                        r_tail   <= r_tail + c_ptr_one;
                        r_count  <= r_count - c_cnt_one;
                    end
                endcase
            end else if (w_fault) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    assign result   = r_result;
    assign valid    = r_valid;
    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign full     = (r_count == c_cnt_max);
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_stream_calc.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_calc
// Description : Self-checking bench for stream_calc. A queue-based model of
//               the calculator predicts every output after each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_calc;

    logic       clk;
    logic       rst;
    logic       apply;
    logic [7:0] in;
    logic [2:0] op;
    logic [7:0] result;
    logic       valid;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       err;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    int m_result;
    int m_valid;
    int m_err;
    int m_code;

    stream_calc #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .apply    (apply),
        .in       (in),
        .op       (op),
        .result   (result),
        .valid    (valid),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".result"},   32'(result),   32'(m_result));
        check({tag, ".valid"},    32'(valid),    32'(m_valid));
        check({tag, ".count"},    32'(count),    32'(q.size()));
        check({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
        check({tag, ".full"},     32'(full),     32'(q.size() == 8));
        check({tag, ".err"},      32'(err),      32'(m_err));
        check({tag, ".err_code"}, 32'(err_code), 32'(m_code));
    endtask

    function automatic void model_reset();
        q.delete();
        m_result = 0;
        m_valid  = 0;
        m_err    = 0;
        m_code   = 0;
    endfunction

    // Behavioural rules: errors in priority order, otherwise execute on the queue
    function automatic void model_step(input int a, input int o, input int v);
        int x, y, r;
        m_valid = 0;
        if (!a || m_err) return;
        if (o == 7) begin
            m_err = 1; m_code = 1;
        end else if ((o == 6 && q.size() == 0) || (o < 5 && q.size() < 2)) begin
            m_err = 1; m_code = 2;
        end else if (o == 5 && q.size() == 8) begin
            m_err = 1; m_code = 3;
        end else if ((o == 3 || o == 4) && q[0] == 0) begin
            m_err = 1; m_code = 4;
        end else if (o == 5) begin
            q.push_back(v);
        end else if (o == 6) begin
            m_result = q.pop_front();
            m_valid  = 1;
        end else begin
            x = q.pop_front();
            y = q.pop_front();
            case (o)
                0:       r = (y + x) % 256;
                1:       r = (y - x + 256) % 256;
                2:       r = (y * x) % 256;
                3:       r = y / x;
                default: r = ((y * 16) / x) % 256;
            endcase
            q.push_back(r);
            m_result = r;
            m_valid  = 1;
        end
    endfunction

    // One clock cycle of stimulus, then compare every output with the model
    task automatic step(input int a, input int o, input int v, input string tag);
        @(negedge clk);
        apply = a[0];
        op    = o[2:0];
        in    = v[7:0];
        @(posedge clk);
        model_step(a, o, v);
        #1;
        check_all(tag);
    endtask

    // Reset asserted away from the clock edge; outputs must clear without a clock
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        apply = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        apply = 1'b0;
        in    = '0;
        op    = '0;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Six pushes of 20, then fold them down
        for (int i = 0; i < 6; i++) step(1, 5, 20, "push20");
        check("push20_count", 32'(count), 32'd6);
        step(1, 0, 0, "add");
        check("add_result", 32'(result), 32'd40);
        step(1, 1, 0, "sub");
        check("sub_result", 32'(result), 32'd0);
        step(1, 2, 0, "mul");
        check("mul_result", 32'(result), 32'd144);
        step(1, 3, 0, "div");
        step(1, 4, 0, "fdiv");
        check("fdiv_count", 32'(count), 32'd1);
        step(0, 6, 0, "idle");
        step(1, 6, 0, "pop1");
        check("pop1_empty", 32'(empty), 32'd1);
        step(1, 6, 0, "pop2");
        check("pop2_code", 32'(err_code), 32'd2);
        step(1, 5, 9, "frozen_push");

        // Invalid opcode
        do_reset("rst_a");
        step(1, 7, 0, "badop");
        check("badop_code", 32'(err_code), 32'd1);

        // Overflow with held PUSH
        do_reset("rst_b");
        for (int i = 0; i < 13; i++) step(1, 5, 3 + i, "push_hold");
        check("ovf_code", 32'(err_code), 32'd3);
        check("ovf_count", 32'(count), 32'd8);

        // Divide by zero, then later applies ignored
        do_reset("rst_c");
        step(1, 5, 0, "push0");
        step(1, 5, 255, "push255");
        step(1, 3, 0, "divz");
        check("divz_code", 32'(err_code), 32'd4);
        step(1, 6, 0, "frozen_pop");
        step(1, 0, 0, "frozen_add");

        // Nonzero fixed-point divide: (7<<4)/2 = 56, and full-FIFO binary op
        do_reset("rst_d");
        step(1, 5, 2, "pushx");
        step(1, 5, 7, "pushy");
        step(1, 4, 0, "fdiv_nz");
        check("fdiv_nz_result", 32'(result), 32'd56);
        for (int i = 0; i < 7; i++) step(1, 5, 10 + i, "fill");
        step(1, 1, 0, "sub_full");
        step(1, 5, 99, "refill");
        for (int i = 0; i < 8; i++) step(1, 6, 0, "drain");

        // Randomized run against the model
        do_reset("rst_e");
        for (int n = 0; n < 600; n++) begin
            int r, o, v, a;
            r = int'($urandom_range(0, 99));
            if (r < 40)      o = 5;
            else if (r < 55) o = 6;
            else if (r < 97) o = int'($urandom_range(0, 4));
            else             o = 7;
            v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            a = ($urandom_range(0, 4) != 0) ? 1 : 0;
            step(a, o, v, "rand");
            if (m_err && $urandom_range(0, 3) == 0) do_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
